// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO stream reader.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

  localparam int SKID_DEPTH     = 2;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_CNT_WIDTH  = 32;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry head/skid register pair; head is always the oldest word.
module fifo_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [1:0]            o_occupancy,
  output logic                  o_valid
);

  occ_state_e            state, state_nxt;
  logic [DATA_WIDTH-1:0] head_q, skid_q;
  logic                  head_ld_push, head_ld_skid, skid_ld;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= EMPTY;
    else         state <= state_nxt;
  end

  // Push is never presented in TWO without a pop; the credit check upstream guarantees it.
  always_comb begin
    state_nxt    = state;
    head_ld_push = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    if (i_flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (i_push) begin
          head_ld_push = 1'b1;
          state_nxt    = ONE;
        end
        ONE: case ({i_pop, i_push})
          2'b11:   head_ld_push = 1'b1;
          2'b10:   state_nxt = EMPTY;
          2'b01: begin
            skid_ld   = 1'b1;
            state_nxt = TWO;
          end
          default: ;
        endcase
        TWO: if (i_pop) begin
          head_ld_skid = 1'b1;
          if (i_push) skid_ld = 1'b1;
          else        state_nxt = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (head_ld_push)      head_q <= i_push_data;
      else if (head_ld_skid) head_q <= skid_q;
      if (skid_ld)           skid_q <= i_push_data;
    end
  end

  assign o_head      = head_q;
  assign o_occupancy = state;
  assign o_valid     = (state != EMPTY);

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (1-cycle read latency) into a valid/ready stream.
// Optional transfer counter enabled by FIFO_RD_XFER_CNT_EN.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  output logic                  o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  input  logic                  i_fifo_empty,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [1:0]            o_occupancy
`ifdef FIFO_RD_XFER_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  o_xfer_count
`endif
);

  localparam logic [2:0] DEPTH3 = 3'(SKID_DEPTH);

  logic       inflight, discard;
  logic       pop, land;
  logic [2:0] credit;

  // A pop during flush is ignored so it neither frees credit nor counts.
  assign pop    = o_valid && i_ready && !i_flush;
  assign credit = DEPTH3 - {1'b0, o_occupancy} - {2'b00, inflight} + {2'b00, pop};
  assign o_fifo_rd_en = i_rstn && !i_fifo_empty && !i_flush && (credit >= 3'd1);
  assign land   = inflight && !discard;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      inflight <= 1'b0;
      discard  <= 1'b0;
    end else begin
      inflight <= o_fifo_rd_en;
      discard  <= i_flush && inflight;
    end
  end

  fifo_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_push      (land),
    .i_push_data (i_fifo_rd_data),
    .i_pop       (pop),
    .i_flush     (i_flush),
    .o_head      (o_data),
    .o_occupancy (o_occupancy),
    .o_valid     (o_valid)
  );

`ifdef FIFO_RD_XFER_CNT_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)  o_xfer_count <= '0;
    else if (pop) o_xfer_count <= o_xfer_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: behavioural sync FIFO feeding fifo_stream_reader, checked with immediate assertions.
module tb_fifo_stream_reader;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rd_en, fifo_empty, flush, valid, ready;
  logic [DW-1:0] rd_data, data, wr_data;
  logic [1:0]    occ;
  logic          wr_en;
`ifdef FIFO_RD_XFER_CNT_EN
  logic [31:0]   xfer;
  logic [31:0]   cnt0;
`endif

  int errors = 0;
  int checks = 0;
  int pulses, sent, got;
  logic [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  // Behavioural FIFO: registered read data, async reset shared with the DUT.
  logic [DW-1:0] mem [0:2047];
  logic [10:0]   wptr, rptr;
  assign fifo_empty = (wptr == rptr);

  always @(posedge clk) if (rstn && wr_en) mem[wptr] <= wr_data;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 11'd1;
      if (rd_en && !fifo_empty) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + 11'd1;
      end
    end
  end

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .o_fifo_rd_en   (rd_en),
    .i_fifo_rd_data (rd_data),
    .i_fifo_empty   (fifo_empty),
    .i_flush        (flush),
    .o_valid        (valid),
    .o_data         (data),
    .i_ready        (ready),
    .o_occupancy    (occ)
`ifdef FIFO_RD_XFER_CNT_EN
    ,
    .o_xfer_count   (xfer)
`endif
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  initial begin
    ready = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0;

    // Reset state
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_occ",   occ,   0);
    chk("rst_data",  data,  0);
    chk("rst_rd_en", rd_en, 0);
    @(negedge clk); rstn = 1'b1;

    // 1: backpressure, two reads fill head+skid then stall
    @(negedge clk); wr_en = 1'b1; wr_data = 64'h11;
    pulses = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      pulses += int'(rd_en);
      if (k == 1)      wr_data = 64'h22;
      else if (k == 2) wr_data = 64'h33;
      else             wr_en = 1'b0;
      if (k >= 4) begin
        chk("bp_occ",  occ,  2);
        chk("bp_data", data, 64'h11);
      end
    end
    chk("bp_pulses", pulses, 2);
    ready = 1'b1;
    chk("bp_w0", {valid, data}, {1'b1, 64'h11});
    @(negedge clk); chk("bp_w1", {valid, data}, {1'b1, 64'h22});
    @(negedge clk); chk("bp_w2", {valid, data}, {1'b1, 64'h33});
    @(negedge clk); chk("bp_drained", valid, 0);
`ifdef FIFO_RD_XFER_CNT_EN
    chk("bp_xfer", xfer, 3);
`endif

    // 2: streaming 16 words back-to-back
    chk("st_empty0", fifo_empty, 1);
`ifdef FIFO_RD_XFER_CNT_EN
    cnt0 = xfer;
`endif
    wr_en = 1'b1; wr_data = 64'd0;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("st_empty_fell", fifo_empty, 0);
        chk("st_rd_first", rd_en, 1);
      end
      if (c <= 2)       chk("st_lat", valid, 0);
      else if (c <= 18) chk("st_word", {valid, data}, {1'b1, 64'(c - 3)});
      else              chk("st_end", valid, 0);
      if (c < 16) wr_data = 64'(c);
      else        wr_en = 1'b0;
    end
`ifdef FIFO_RD_XFER_CNT_EN
    chk("st_xfer16", xfer - cnt0, 16);
`endif

    // 3: flush with a read in flight
    wr_en = 1'b1; wr_data = 64'hAA;
    @(negedge clk);
    chk("fl_rd_aa", rd_en, 1);
    wr_data = 64'hBB;
    @(negedge clk);
    wr_en = 1'b0; flush = 1'b1;
    #1 chk("fl_rd_block", rd_en, 0);
    @(negedge clk);
    chk("fl_occ0",   occ,   0);
    chk("fl_valid0", valid, 0);
    flush = 1'b0;
    #1 chk("fl_rd_bb", rd_en, 1);
    @(negedge clk); chk("fl_gap", valid, 0);
    @(negedge clk); chk("fl_bb", {valid, data}, {1'b1, 64'hBB});
    @(negedge clk); chk("fl_end", valid, 0);

    // 4: empty guard
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ready = k[0];
      #1 chk("eg_idle", {rd_en, valid}, 0);
    end

    // 5: async reset while holding two words
    ready = 1'b0;
    wr_en = 1'b1; wr_data = 64'h51;
    @(negedge clk); wr_data = 64'h52;
    @(negedge clk); wr_data = 64'h53;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ar_occ2", occ, 2);
    chk("ar_head", data, 64'h51);
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid", valid, 0);
    chk("ar_occ",   occ,   0);
    chk("ar_data",  data,  0);
    chk("ar_rd_en", rd_en, 0);
`ifdef FIFO_RD_XFER_CNT_EN
    chk("ar_xfer", xfer, 0);
`endif
    @(negedge clk); rstn = 1'b1; ready = 1'b1;
    wr_en = 1'b1; wr_data = 64'h61;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk); chk("ar_lat", valid, 0);
    @(negedge clk); chk("ar_resume", {valid, data}, {1'b1, 64'h61});
    @(negedge clk); chk("ar_end", valid, 0);

    // 6: random ready and writes against a scoreboard
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 6000 && got < 1000; cyc++) begin
      @(negedge clk);
      ready = 1'($urandom_range(0, 1));
      if (sent < 1000 && $urandom_range(0, 3) != 0) begin
        wr_en   = 1'b1;
        wr_data = {$urandom, $urandom};
        sb_q.push_back(wr_data);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      #1;
      if (valid && ready) begin
        if (sb_q.size() == 0) chk("rnd_extra_word", valid, 0);
        else                  chk("rnd_data", data, sb_q.pop_front());
        got++;
      end
      chk("rnd_occ_le2", occ <= 2'd2, 1);
      chk("rnd_rd_empty", rd_en && fifo_empty, 0);
    end
    wr_en = 1'b0;
    chk("rnd_count", got, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Consumer-side drain engine for the team's synchronous FIFO.
- Drives the FIFO read port (read enable, 1-cycle registered read data, empty flag) and presents the words as a valid/ready stream to a downstream block.
- Holds up to 2 words locally (head + skid), so a stalling consumer never loses data.
- Sustains 1 word/cycle when the FIFO stays non-empty and the consumer holds ready high.

Parameters:
- DATA_WIDTH, 64, word width; must match the FIFO.
- CNT_WIDTH, 32, width of the optional transfer counter.

Ports:
- i_clk  in  1  single clock.
- i_rstn  in  1  reset: asynchronous assert, active-low.
- o_fifo_rd_en  out  1  FIFO read request.
- i_fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid 1 cycle after an accepted read.
- i_fifo_empty  in  1  FIFO empty flag.
- i_flush  in  1  synchronous drop of all locally held and in-flight words.
- o_valid  out  1  stream word valid.
- o_data  out  DATA_WIDTH  stream word (head).
- i_ready  in  1  consumer accepts the head word.
- o_occupancy  out  2  local words held (0..2).
- o_xfer_count  out  CNT_WIDTH  present only with FIFO_RD_XFER_CNT_EN.

Behaviour:
- Reset (i_rstn low, async):
  - o_valid=0, o_data=0, o_occupancy=0, o_xfer_count=0.
  - In-flight flag and discard flag cleared.
  - o_fifo_rd_en held 0 while reset is asserted.
- Occupancy state machine:
  - States: EMPTY (0), ONE (1), TWO (2). o_occupancy mirrors the state.
  - o_valid = (state != EMPTY).
  - o_data is always the head slot.
- Pop: o_valid && i_ready at a clock edge.
  - Head is replaced by the skid slot, or by landing data if the skid slot is empty.
- Read issue, combinational:
  - o_fifo_rd_en = !i_fifo_empty && !i_flush && (2 - occ - inflight + pop) >= 1.
  - Never assert when i_fifo_empty=1.
- In-flight tracking:
  - inflight <= o_fifo_rd_en, registered.
  - When inflight=1 and discard=0, i_fifo_rd_data is written into the first free slot after this cycle's pop.
- Ordering: strict FIFO order; no word is duplicated or dropped except on flush.
- Latency:
  - Read issued in cycle N; data sampled at the end of N+1; o_valid=1 in N+2.
  - First-word latency from i_fifo_empty falling is 2 cycles.
- Throughput: at steady state (occ=1, inflight=1, i_ready=1) a read is issued every cycle, giving 1 word/cycle.
- Stability: while o_valid=1 and i_ready=0, o_data and o_valid hold unchanged.
- Simultaneous pop and land in state ONE: head takes the landing word; state stays ONE.
- Simultaneous pop and land in state TWO: skid moves to head, landing word goes to skid; state stays TWO.
  - The credit equation guarantees a land can never overflow TWO.
- Flush (i_flush=1 at an edge):
  - Next state EMPTY, o_valid=0, o_fifo_rd_en=0 that cycle.
  - If inflight=1, discard<=1 and the word arriving next cycle is dropped.
  - A pop in the flush cycle is ignored; the word is not counted.
- Reset mid-operation: all state clears immediately. The FIFO's own reset is expected to be asserted by the same i_rstn.
- Width rules:
  - Credit arithmetic done in 3 bits, unsigned.
  - o_xfer_count wraps modulo 2^CNT_WIDTH.

Optional Feature:
- Macro: FIFO_RD_XFER_CNT_EN.
- Defined:
  - o_xfer_count increments by 1 on every pop, flush cycles excluded, and wraps at 2^CNT_WIDTH.
  - i_flush does not clear it; only reset does.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Package fifo_rd_pkg:
  - Occupancy state enum (EMPTY/ONE/TWO).
  - Constant SKID_DEPTH=2.
  - Default CNT_WIDTH.
- Sub-module fifo_skid_buf: the 2-entry head/skid register pair with push/pop/flush and occupancy output.
- fifo_stream_reader keeps read-issue credit, in-flight/discard tracking and the optional counter.

Test Plan:
1. Backpressure: FIFO preloaded 0x11,0x22,0x33; i_ready=0 for 10 cycles then 1. Required:
   - o_fifo_rd_en pulses exactly twice; o_occupancy=2 and o_data=0x11 stable throughout.
   - Then 0x11,0x22,0x33 are delivered in consecutive cycles.
2. Streaming: 16 words 0..15 written back-to-back, i_ready=1. Required:
   - First o_valid 2 cycles after i_fifo_empty falls.
   - 16 contiguous valid cycles in order; o_xfer_count=16 when enabled.
3. Flush with a read in flight: i_flush asserted in the cycle after o_fifo_rd_en for word 0xAA. Required:
   - 0xAA never appears on o_data; o_occupancy=0 next cycle.
   - The following word 0xBB is delivered normally.
4. Empty guard: i_fifo_empty=1 for 20 cycles, i_ready toggling. Required: o_fifo_rd_en=0 and o_valid=0 throughout.
5. Async reset mid-stream: i_rstn low between clock edges while occupancy=2. Required:
   - o_valid=0, o_occupancy=0 and o_data=0 immediately, with no clock edge.
   - After release, data resumes from the FIFO's reset state.
6. Random i_ready (50%) with 1000 random words. Required:
   - Scoreboard order matches exactly.
   - o_occupancy never exceeds 2; no read is issued while empty.
